branch_rs: RTL and testbench
============================

BRANCH_RS -- requirements
Module: branch_rs

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 rdy  input  1  global ready; when low, all state and outputs hold.
REQ-004 alloc_en_in  input  1  allocator dispatches one branch this cycle.
REQ-005 alloc_op_in  input  sinst_t  branch opcode (BEQ/BNE/BLT/BGE/BLTU/BGEU).
REQ-006 alloc_pc_in  input  addr_t  branch instruction PC.
REQ-007 alloc_offset_in  input  dword_t  sign-extended branch offset.
REQ-008 alloc_tagx_in / alloc_tagy_in  input  regtag_t  operand producer tags; UNLOCKED = value already present.
REQ-009 alloc_datax_in / alloc_datay_in  input  dword_t  operand values, valid when the matching tag is UNLOCKED.
REQ-010 cdb_en_in  input  1  result broadcast valid.
REQ-011 cdb_tag_in  input  regtag_t  tag of broadcast result (never UNLOCKED when cdb_en_in=1).
REQ-012 cdb_data_in  input  dword_t  broadcast result value.
REQ-013 flush_in  input  1  mispredict/redirect; discard all held branches.
REQ-014 full_out  output  1  registered; 1 when all 4 entries are occupied.
REQ-015 branch_busy_out  output  1  registered; issue valid to the branch execute stage.
REQ-016 branch_op_out  output  sinst_t  issued opcode.
REQ-017 pc_out / offset_out  output  addr_t / dword_t  issued PC and offset.
REQ-018 branch_tagx_out / branch_tagy_out  output  regtag_t  always UNLOCKED while branch_busy_out=1.
REQ-019 branch_datax_out / branch_datay_out  output  dword_t  resolved operand values.

Function
REQ-020 4-entry circular buffer: head/tail pointers (2 bits, wrap 3->0), count 0..4.
REQ-021 Entry fields: op, pc, offset, tagx, tagy, datax, datay.
REQ-022 Allocation: alloc_en_in=1 and full_out=0 writes entry at tail, tail+1, count+1; alloc_en_in while full_out=1 is ignored (allocator contract violation, no state change).
REQ-023 Dispatch-time forwarding: if cdb_en_in=1 and cdb_tag_in equals an incoming non-UNLOCKED tag the same cycle, the entry stores UNLOCKED and cdb_data_in for that operand.
REQ-024 Wakeup: each cycle every occupied entry with tagx (tagy) == cdb_tag_in and cdb_en_in=1 sets that tag UNLOCKED and captures cdb_data_in; both operands may wake on the same broadcast.
REQ-025 Issue in program order: only the head entry may issue; it issues when both stored tags are UNLOCKED at the start of the cycle.
REQ-026 Issue: registered outputs load the head entry, branch_busy_out=1 for exactly one cycle, head+1, count-1; otherwise branch_busy_out=0 next cycle (other outputs hold).
REQ-027 Latency: branch dispatched with both operands ready into an empty buffer at edge N -> branch_busy_out=1 after edge N+1; wakeup on head at edge N -> issue after edge N+1 (no same-cycle bypass to output).
REQ-028 Simultaneous allocate and issue: count unchanged, both pointers advance; allowed when count=4 only if full_out was 0 (never), so full blocks allocation that cycle.
REQ-029 full_out reflects count after the update (count==4), registered.
REQ-030 Flush: flush_in=1 has priority over allocate, wakeup and issue; next state count=0, head=tail=0, branch_busy_out=0, full_out=0.
REQ-031 rdy=0: no allocation, wakeup, issue or flush takes effect; all registers hold. CDB values broadcast while rdy=0 are lost (producer holds under rdy).

Reset
REQ-032 rst=1 at rising edge (regardless of rdy): count=0, head=tail=0, all entries invalid, full_out=0, branch_busy_out=0, op/pc/offset/data outputs 0, tag outputs UNLOCKED.
REQ-033 Reset mid-operation discards all held branches; no issue in the cycle following reset.

Structure
REQ-034 addr_t, dword_t (32 bits), regtag_t, sinst_t, UNLOCKED and branch opcode constants come from the shared defines header; entry count 4 is a local parameter.
REQ-035 Single module; no sub-modules (per-entry wakeup comparators inline via generate loop).

Verification
REQ-036 Empty buffer, dispatch BEQ pc=0x100 offset=8 tags UNLOCKED x=y=5 -> busy_out=1 one cycle later with op BEQ, pc 0x100, data 5/5.
REQ-037 Dispatch BNE tagx=3, then cdb tag=3 data=0x2A two cycles later -> issue the cycle after broadcast, datax=0x2A, tagx_out UNLOCKED.
REQ-038 Dispatch 4 branches with tagx=7 unresolved -> full_out=1, 5th dispatch ignored; cdb tag=7 -> 4 issues on consecutive cycles in dispatch order, full_out drops after first issue.
REQ-039 Head blocked on tag 2, second entry ready -> second does not issue until head issues (in-order).
REQ-040 Three entries held, flush_in=1 with concurrent alloc_en_in -> count=0, busy_out=0, new branch not captured; rst mid-stream likewise clears all.

Source files
------------

// File: rtl/branch_rs_pkg.sv
// Shared types for the branch reservation station: operand/tag widths,
// branch opcodes and the stored entry layout.
package branch_rs_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] dword_t;
  typedef logic [3:0]  regtag_t;
  typedef logic [2:0]  sinst_t;

  localparam regtag_t UNLOCKED = 4'd0;

  localparam sinst_t BR_BEQ  = 3'd0;
  localparam sinst_t BR_BNE  = 3'd1;
  localparam sinst_t BR_BLT  = 3'd4;
  localparam sinst_t BR_BGE  = 3'd5;
  localparam sinst_t BR_BLTU = 3'd6;
  localparam sinst_t BR_BGEU = 3'd7;

  typedef struct packed {
    sinst_t  op;
    addr_t   pc;
    dword_t  offset;
    regtag_t tagx;
    regtag_t tagy;
    dword_t  datax;
    dword_t  datay;
  } rs_entry_t;

  function automatic logic ops_ready(rs_entry_t e);
    return (e.tagx == UNLOCKED) && (e.tagy == UNLOCKED);
  endfunction

endpackage

// File: rtl/branch_rs_if.sv
// Dispatch, result-broadcast, flush and issue signals of the branch
// reservation station; master drives dispatch/CDB, slave is the station.
interface branch_rs_if;
  import branch_rs_pkg::*;

  logic    alloc_en_in;
  sinst_t  alloc_op_in;
  addr_t   alloc_pc_in;
  dword_t  alloc_offset_in;
  regtag_t alloc_tagx_in;
  regtag_t alloc_tagy_in;
  dword_t  alloc_datax_in;
  dword_t  alloc_datay_in;
  logic    cdb_en_in;
  regtag_t cdb_tag_in;
  dword_t  cdb_data_in;
  logic    flush_in;

  logic    full_out;
  logic    branch_busy_out;
  sinst_t  branch_op_out;
  addr_t   pc_out;
  dword_t  offset_out;
  regtag_t branch_tagx_out;
  regtag_t branch_tagy_out;
  dword_t  branch_datax_out;
  dword_t  branch_datay_out;

  modport master (
    output alloc_en_in, alloc_op_in, alloc_pc_in, alloc_offset_in,
           alloc_tagx_in, alloc_tagy_in, alloc_datax_in, alloc_datay_in,
           cdb_en_in, cdb_tag_in, cdb_data_in, flush_in,
    input  full_out, branch_busy_out, branch_op_out, pc_out, offset_out,
           branch_tagx_out, branch_tagy_out, branch_datax_out, branch_datay_out
  );

  modport slave (
    input  alloc_en_in, alloc_op_in, alloc_pc_in, alloc_offset_in,
           alloc_tagx_in, alloc_tagy_in, alloc_datax_in, alloc_datay_in,
           cdb_en_in, cdb_tag_in, cdb_data_in, flush_in,
    output full_out, branch_busy_out, branch_op_out, pc_out, offset_out,
           branch_tagx_out, branch_tagy_out, branch_datax_out, branch_datay_out
  );

endinterface

// File: rtl/branch_rs.sv
// 4-entry in-order branch reservation station: captures operands from the
// CDB, issues the head entry once both operands are present.
module branch_rs
  import branch_rs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  branch_rs_if.slave  rs
);

  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [2:0]       count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             full_q, full_d;
  logic             busy_q, busy_d;
  rs_entry_t        out_q, out_d;
  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_d [DEPTH];
  rs_entry_t        new_ent;
  logic [DEPTH-1:0] wake_x, wake_y;
  logic             do_issue, do_alloc;

  for (genvar i = 0; i < DEPTH; i++) begin : g_wake
    assign wake_x[i] = rs.cdb_en_in && vld_q[i] && (ent_q[i].tagx == rs.cdb_tag_in);
    assign wake_y[i] = rs.cdb_en_in && vld_q[i] && (ent_q[i].tagy == rs.cdb_tag_in);
  end

  // Incoming branch picks up a same-cycle broadcast so it never misses its producer.
  always_comb begin
    new_ent.op     = rs.alloc_op_in;
    new_ent.pc     = rs.alloc_pc_in;
    new_ent.offset = rs.alloc_offset_in;
    new_ent.tagx   = rs.alloc_tagx_in;
    new_ent.tagy   = rs.alloc_tagy_in;
    new_ent.datax  = rs.alloc_datax_in;
    new_ent.datay  = rs.alloc_datay_in;
    if (rs.cdb_en_in && rs.alloc_tagx_in != UNLOCKED && rs.alloc_tagx_in == rs.cdb_tag_in) begin
      new_ent.tagx  = UNLOCKED;
      new_ent.datax = rs.cdb_data_in;
    end
    if (rs.cdb_en_in && rs.alloc_tagy_in != UNLOCKED && rs.alloc_tagy_in == rs.cdb_tag_in) begin
      new_ent.tagy  = UNLOCKED;
      new_ent.datay = rs.cdb_data_in;
    end
  end

  assign do_issue = (count_q != 3'd0) && ops_ready(ent_q[head_q]);
  assign do_alloc = rs.alloc_en_in && !full_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    full_d  = full_q;
    busy_d  = busy_q;
    out_d   = out_q;
    ent_d   = ent_q;
    if (rdy) begin
      if (rs.flush_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        vld_d   = '0;
        full_d  = 1'b0;
        busy_d  = 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wake_x[i]) begin
            ent_d[i].tagx  = UNLOCKED;
            ent_d[i].datax = rs.cdb_data_in;
          end
          if (wake_y[i]) begin
            ent_d[i].tagy  = UNLOCKED;
            ent_d[i].datay = rs.cdb_data_in;
          end
        end
        // Issue reads pre-wakeup state: a broadcast never bypasses straight to the output.
        busy_d = do_issue;
        if (do_issue) begin
          out_d         = ent_q[head_q];
          vld_d[head_q] = 1'b0;
          head_d        = head_q + 2'd1;
        end
        if (do_alloc) begin
          ent_d[tail_q] = new_ent;
          vld_d[tail_q] = 1'b1;
          tail_d        = tail_q + 2'd1;
        end
        count_d = count_q + 3'(do_alloc) - 3'(do_issue);
        full_d  = (count_d == 3'd4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      out_q   <= '{op: '0, pc: '0, offset: '0, tagx: UNLOCKED, tagy: UNLOCKED,
                   datax: '0, datay: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
    end
  end

  // Payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign rs.full_out         = full_q;
  assign rs.branch_busy_out  = busy_q;
  assign rs.branch_op_out    = out_q.op;
  assign rs.pc_out           = out_q.pc;
  assign rs.offset_out       = out_q.offset;
  assign rs.branch_tagx_out  = out_q.tagx;
  assign rs.branch_tagy_out  = out_q.tagy;
  assign rs.branch_datax_out = out_q.datax;
  assign rs.branch_datay_out = out_q.datay;

endmodule

// File: tb/tb_branch_rs.sv
// Bench for branch_rs: directed vector table for the listed scenarios plus a
// random run, both checked against a queue-based reference model.
module tb_branch_rs;
  import branch_rs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  branch_rs_if bus();

  branch_rs dut (.clk(clk), .rst(rst), .rdy(rdy), .rs(bus.slave));

  typedef struct {
    sinst_t  op;
    addr_t   pc;
    dword_t  off;
    regtag_t tx;
    regtag_t ty;
    dword_t  dx;
    dword_t  dy;
  } m_ent_t;

  typedef struct {
    bit      aen;
    addr_t   pc;
    regtag_t tx;
    dword_t  dx;
    bit      cen;
    regtag_t ctag;
    dword_t  cdata;
    bit      fl;
    bit      rs;
    bit      rd;
    bit      e_busy;
    bit      e_full;
    addr_t   e_pc;
    dword_t  e_dx;
  } vec_t;

  m_ent_t mq[$];
  m_ent_t m_out;
  bit     m_busy, m_full;
  int     n_chk = 0;
  int     n_fail = 0;
  vec_t   tbl[$];
  sinst_t ops[6] = '{BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};

  function automatic void check(string name, logic [159:0] act, logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic vec_t V(bit aen, addr_t pc, regtag_t tx, dword_t dx,
                             bit cen, regtag_t ctag, dword_t cd,
                             bit fl, bit rs_i, bit rd,
                             bit eb, bit ef, addr_t epc, dword_t edx);
    vec_t v;
    v.aen = aen; v.pc = pc; v.tx = tx; v.dx = dx;
    v.cen = cen; v.ctag = ctag; v.cdata = cd;
    v.fl = fl; v.rs = rs_i; v.rd = rd;
    v.e_busy = eb; v.e_full = ef; v.e_pc = epc; v.e_dx = edx;
    return v;
  endfunction

  // Reference: a plain FIFO of waiting branches, at most four deep.
  task automatic model_step();
    m_ent_t e, n;
    bit iss, acc;
    if (rst) begin
      mq.delete();
      m_busy = 0; m_full = 0;
      m_out = '{op: 0, pc: 0, off: 0, tx: UNLOCKED, ty: UNLOCKED, dx: 0, dy: 0};
    end else if (rdy) begin
      if (bus.flush_in) begin
        mq.delete();
        m_busy = 0; m_full = 0;
      end else begin
        iss = (mq.size() > 0) && mq[0].tx == UNLOCKED && mq[0].ty == UNLOCKED;
        acc = bus.alloc_en_in && (mq.size() < 4);
        if (iss) m_out = mq.pop_front();
        for (int i = 0; i < mq.size(); i++) begin
          e = mq[i];
          if (bus.cdb_en_in && e.tx == bus.cdb_tag_in) begin e.tx = UNLOCKED; e.dx = bus.cdb_data_in; end
          if (bus.cdb_en_in && e.ty == bus.cdb_tag_in) begin e.ty = UNLOCKED; e.dy = bus.cdb_data_in; end
          mq[i] = e;
        end
        if (acc) begin
          n = '{op: bus.alloc_op_in, pc: bus.alloc_pc_in, off: bus.alloc_offset_in,
                tx: bus.alloc_tagx_in, ty: bus.alloc_tagy_in,
                dx: bus.alloc_datax_in, dy: bus.alloc_datay_in};
          if (bus.cdb_en_in && n.tx != UNLOCKED && n.tx == bus.cdb_tag_in) begin n.tx = UNLOCKED; n.dx = bus.cdb_data_in; end
          if (bus.cdb_en_in && n.ty != UNLOCKED && n.ty == bus.cdb_tag_in) begin n.ty = UNLOCKED; n.dy = bus.cdb_data_in; end
          mq.push_back(n);
        end
        m_busy = iss;
        m_full = (mq.size() == 4);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model_busy", 160'(bus.branch_busy_out), 160'(m_busy));
    check("model_full", 160'(bus.full_out), 160'(m_full));
    check("model_outs",
          160'({bus.branch_op_out, bus.pc_out, bus.offset_out, bus.branch_tagx_out,
                bus.branch_tagy_out, bus.branch_datax_out, bus.branch_datay_out}),
          160'({m_out.op, m_out.pc, m_out.off, m_out.tx, m_out.ty, m_out.dx, m_out.dy}));
  endtask

  task automatic drive_idle();
    bus.alloc_en_in = 0; bus.alloc_op_in = BR_BEQ; bus.alloc_pc_in = 0;
    bus.alloc_offset_in = 32'd8; bus.alloc_tagx_in = UNLOCKED; bus.alloc_tagy_in = UNLOCKED;
    bus.alloc_datax_in = 0; bus.alloc_datay_in = 0;
    bus.cdb_en_in = 0; bus.cdb_tag_in = 4'd1; bus.cdb_data_in = 0;
    bus.flush_in = 0; rst = 0; rdy = 1;
  endtask

  initial begin
    drive_idle();
    // reset
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 1, 1, 0, 0, 0,     0));
    // single ready branch
    tbl.push_back(V(1, 'h100, 0, 5,     0, 0, 0,     0, 0, 1, 0, 0, 0,     0));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 1, 0, 'h100, 5));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h100, 5));
    // wakeup two cycles after dispatch
    tbl.push_back(V(1, 'h200, 3, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h100, 5));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h100, 5));
    tbl.push_back(V(0, 0,     0, 0,     1, 3, 'h2A,  0, 0, 1, 0, 0, 'h100, 5));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 1, 0, 'h200, 'h2A));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h200, 'h2A));
    // fill, overflow dispatch ignored, drain in order
    tbl.push_back(V(1, 'h300, 7, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h200, 'h2A));
    tbl.push_back(V(1, 'h304, 7, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h200, 'h2A));
    tbl.push_back(V(1, 'h308, 7, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h200, 'h2A));
    tbl.push_back(V(1, 'h30C, 7, 0,     0, 0, 0,     0, 0, 1, 0, 1, 'h200, 'h2A));
    tbl.push_back(V(1, 'h310, 0, 9,     0, 0, 0,     0, 0, 1, 0, 1, 'h200, 'h2A));
    tbl.push_back(V(0, 0,     0, 0,     1, 7, 'h77,  0, 0, 1, 0, 1, 'h200, 'h2A));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 1, 0, 'h300, 'h77));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 1, 0, 'h304, 'h77));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 1, 0, 'h308, 'h77));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 1, 0, 'h30C, 'h77));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h30C, 'h77));
    // blocked head holds back a ready follower
    tbl.push_back(V(1, 'h400, 2, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h30C, 'h77));
    tbl.push_back(V(1, 'h404, 0, 'h11,  0, 0, 0,     0, 0, 1, 0, 0, 'h30C, 'h77));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h30C, 'h77));
    tbl.push_back(V(0, 0,     0, 0,     1, 2, 'h22,  0, 0, 1, 0, 0, 'h30C, 'h77));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 1, 0, 'h400, 'h22));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 1, 0, 'h404, 'h11));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h404, 'h11));
    // flush beats a concurrent dispatch
    tbl.push_back(V(1, 'h500, 5, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h404, 'h11));
    tbl.push_back(V(1, 'h504, 5, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h404, 'h11));
    tbl.push_back(V(1, 'h508, 5, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h404, 'h11));
    tbl.push_back(V(1, 'h50C, 0, 'h33,  0, 0, 0,     1, 0, 1, 0, 0, 'h404, 'h11));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h404, 'h11));
    tbl.push_back(V(0, 0,     0, 0,     1, 5, 'h55,  0, 0, 1, 0, 0, 'h404, 'h11));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h404, 'h11));
    // reset mid-stream
    tbl.push_back(V(1, 'h600, 0, 1,     0, 0, 0,     0, 0, 1, 0, 0, 'h404, 'h11));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 1, 1, 0, 0, 0,     0));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 0,     0));
    // rdy low blocks dispatch and holds issue
    tbl.push_back(V(1, 'h700, 0, 2,     0, 0, 0,     0, 0, 0, 0, 0, 0,     0));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 0,     0));
    tbl.push_back(V(1, 'h704, 0, 3,     0, 0, 0,     0, 0, 1, 0, 0, 0,     0));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 0, 0, 0, 0,     0));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 1, 0, 'h704, 3));
    // dispatch-time forwarding
    tbl.push_back(V(1, 'h800, 4, 0,     1, 4, 'h44,  0, 0, 1, 0, 0, 'h704, 3));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 1, 0, 'h800, 'h44));
    tbl.push_back(V(0, 0,     0, 0,     0, 0, 0,     0, 0, 1, 0, 0, 'h800, 'h44));

    for (int k = 0; k < tbl.size(); k++) begin
      bus.alloc_en_in    = tbl[k].aen;
      bus.alloc_op_in    = (tbl[k].pc[2]) ? BR_BNE : BR_BEQ;
      bus.alloc_pc_in    = tbl[k].pc;
      bus.alloc_tagx_in  = tbl[k].tx;
      bus.alloc_datax_in = tbl[k].dx;
      bus.alloc_datay_in = tbl[k].dx;
      bus.cdb_en_in      = tbl[k].cen;
      bus.cdb_tag_in     = (tbl[k].cen) ? tbl[k].ctag : 4'd1;
      bus.cdb_data_in    = tbl[k].cdata;
      bus.flush_in       = tbl[k].fl;
      rst                = tbl[k].rs;
      rdy                = tbl[k].rd;
      step();
      check($sformatf("vec%0d_busy", k), 160'(bus.branch_busy_out), 160'(tbl[k].e_busy));
      check($sformatf("vec%0d_full", k), 160'(bus.full_out), 160'(tbl[k].e_full));
      check($sformatf("vec%0d_pc", k), 160'(bus.pc_out), 160'(tbl[k].e_pc));
      check($sformatf("vec%0d_dx", k), 160'(bus.branch_datax_out), 160'(tbl[k].e_dx));
      if (tbl[k].e_busy)
        check($sformatf("vec%0d_tagx", k), 160'(bus.branch_tagx_out), 160'(UNLOCKED));
    end

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      rdy  = ($urandom_range(0, 7) != 0);
      bus.flush_in        = ($urandom_range(0, 29) == 0);
      bus.alloc_en_in     = $urandom_range(0, 1);
      bus.alloc_op_in     = ops[$urandom_range(0, 5)];
      bus.alloc_pc_in     = $urandom;
      bus.alloc_offset_in = $urandom;
      bus.alloc_tagx_in   = ($urandom_range(0, 2) == 0) ? regtag_t'($urandom_range(1, 7)) : UNLOCKED;
      bus.alloc_tagy_in   = ($urandom_range(0, 2) == 0) ? regtag_t'($urandom_range(1, 7)) : UNLOCKED;
      bus.alloc_datax_in  = $urandom;
      bus.alloc_datay_in  = $urandom;
      bus.cdb_en_in       = $urandom_range(0, 1);
      bus.cdb_tag_in      = regtag_t'($urandom_range(1, 7));
      bus.cdb_data_in     = $urandom;
      step();
      if (bus.branch_busy_out === 1'b1)
        check("rand_tags_unlocked", 160'({bus.branch_tagx_out, bus.branch_tagy_out}),
              160'({UNLOCKED, UNLOCKED}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
